// File: rtl/aq_djpeg_mcu_sched.sv
// Double-buffered MCU scheduler between the IDCT output and the colour converter.
// The producer fills one bank while the converter drains the other. MCUs are dispatched in raster order.
module aq_djpeg_mcu_sched #(
  parameter int MCU_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DataInit,
  input  logic [MCU_W-1:0] ImageMcuW,
  input  logic [MCU_W-1:0] ImageMcuH,
  input  logic             WrDone,
  output logic             WrBank,
  output logic             WrReady,
  output logic             RdEnable,
  output logic             RdBank,
  output logic [MCU_W-1:0] RdBlockX,
  output logic [MCU_W-1:0] RdBlockY,
  input  logic             RdNext,
  output logic             FrameDone,
  output logic             Busy,
  output logic             SeqErr
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, stateNext;
  logic [1:0]       valid, validNext;
  logic             wrPtr, wrPtrNext;
  logic             rdPtr, rdPtrNext;
  logic [MCU_W-1:0] curX, curXNext;
  logic [MCU_W-1:0] curY, curYNext;
  logic             rdEnReg, rdEnNext;
  logic             frameDoneReg, frameDoneNext;
  logic             seqErrReg, seqErrNext;
  logic             rdAccept, wrAccept;
  logic             lastCol, lastRow;

  always_ff @(posedge clk) begin
    if (!rst || DataInit) begin
      state        <= IDLE;
      valid        <= 2'b00;
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      curX         <= '0;
      curY         <= '0;
      rdEnReg      <= 1'b0;
      frameDoneReg <= 1'b0;
      seqErrReg    <= 1'b0;
    end else begin
      state        <= stateNext;
      valid        <= validNext;
      wrPtr        <= wrPtrNext;
      rdPtr        <= rdPtrNext;
      curX         <= curXNext;
      curY         <= curYNext;
      rdEnReg      <= rdEnNext;
      frameDoneReg <= frameDoneNext;
      seqErrReg    <= seqErrNext;
    end
  end

  // A write into a full bank is still accepted when that same bank is being freed
  // this cycle. The clear is applied first, so the set wins and no update is lost.
  always_comb begin
    stateNext     = state;
    validNext     = valid;
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    curXNext      = curX;
    curYNext      = curY;
    rdEnNext      = 1'b0;
    frameDoneNext = 1'b0;
    seqErrNext    = seqErrReg;

    rdAccept = RdNext && (state == WAIT);
    wrAccept = WrDone && (!valid[wrPtr] || (rdAccept && (rdPtr == wrPtr)));
    lastCol  = (curX == ImageMcuW - 1'b1);
    lastRow  = (curY == ImageMcuH - 1'b1);

    if ((RdNext && !rdAccept) || (WrDone && !wrAccept))
      seqErrNext = 1'b1;

    if (rdAccept) begin
      validNext[rdPtr] = 1'b0;
      rdPtrNext        = ~rdPtr;
    end
    if (wrAccept) begin
      validNext[wrPtr] = 1'b1;
      wrPtrNext        = ~wrPtr;
    end

    case (state)
      IDLE: begin
        if (valid[rdPtr]) begin
          rdEnNext  = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (rdAccept) begin
          if (lastCol && lastRow) begin
            stateNext     = DONE;
            frameDoneNext = 1'b1;
          end else if (lastCol) begin
            curXNext  = '0;
            curYNext  = curY + 1'b1;
            stateNext = IDLE;
          end else begin
            curXNext  = curX + 1'b1;
            stateNext = IDLE;
          end
        end
      end
      DONE: begin
        stateNext = DONE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign WrBank    = wrPtr;
  assign WrReady   = !valid[wrPtr];
  assign RdEnable  = rdEnReg;
  assign RdBank    = rdPtr;
  assign RdBlockX  = curX;
  assign RdBlockY  = curY;
  assign FrameDone = frameDoneReg;
  assign Busy      = (state != DONE);
  assign SeqErr    = seqErrReg;

endmodule
